// File: rtl/ram_slot_arbiter.sv
// Time-slot arbiter sharing one synchronous single-port RAM between CHANNELS requesters.
// Supports strict TDM or ch0-priority + round-robin, with an optional every-clock turbo tick.
module ram_slot_arbiter #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DIV      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         turbo,
  input  logic                         mode,
  input  logic [CHANNELS-1:0]          req,
  input  logic [CHANNELS-1:0]          we,
  input  logic [CHANNELS*ADDR_W-1:0]   addr,
  input  logic [CHANNELS*DATA_W-1:0]   wdata,
  output logic [CHANNELS-1:0]          ack,
  output logic [DATA_W-1:0]            rdata,
  output logic                         tick,
  output logic                         busy,
  output logic [2:0]                   grant_id,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(CHANNELS);
  localparam int unsigned LAST  = CHANNELS - 1;

  if (DIV < 4) begin : g_div_check
    $error("ram_slot_arbiter: DIV must be at least 4");
  end
  if (CHANNELS < 2 || CHANNELS > 8) begin : g_ch_check
    $error("ram_slot_arbiter: CHANNELS must be in 2..8");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic             turbo_q;
  logic [IDX_W-1:0] sp;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] g_idx;
  logic             wr_q;
  logic             win_valid;
  logic [IDX_W-1:0] win;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Slot divider; turbo is registered so a switch lands on the next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      turbo_q <= 1'b0;
    end else begin
      turbo_q <= turbo;
      div_cnt <= (div_cnt == CNT_W'(DIV - 1)) ? '0 : div_cnt + CNT_W'(1);
    end
  end

  assign tick = turbo_q | (div_cnt == CNT_W'(DIV - 1));

  // Round-robin search position, wrapping within 1..LAST
  function automatic logic [IDX_W-1:0] rr_pos(input logic [IDX_W-1:0] base, input int unsigned k);
    int unsigned p;
    p = 32'(base) + k;
    if (p > LAST) p = p - LAST;
    return IDX_W'(p);
  endfunction

  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    if (!mode) begin
      win_valid = req[sp];
      win       = sp;
    end else if (req[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int unsigned k = 0; k < LAST; k++) begin
        if (!win_valid && req[rr_pos(rr, k)]) begin
          win_valid = 1'b1;
          win       = rr_pos(rr, k);
        end
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (win == IDX_W'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Access sequencer; grants are only decided in IDLE on a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      g_idx     <= '0;
      wr_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sp        <= '0;
      rr        <= IDX_W'(1);
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            if (!mode) sp <= (sp == IDX_W'(LAST)) ? '0 : sp + IDX_W'(1);
            if (win_valid) begin
              state     <= ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              wr_q      <= sel_we;
              busy      <= 1'b1;
              grant_id  <= 3'(win);
              g_idx     <= win;
              if (mode && win != '0)
                rr <= (win == IDX_W'(LAST)) ? IDX_W'(1) : win + IDX_W'(1);
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (!wr_q) rdata <= mem_rdata;
          ack   <= CHANNELS'(1) << g_idx;
          state <= DONE;
        end
        DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed bench for ram_slot_arbiter with a one-clock-latency read-first RAM model.
// Cycle k below means the k-th clock after the negedge on which reset was released.
module tb_ram_slot_arbiter;

  logic        clk;
  logic        reset;
  logic        turbo;
  logic        mode;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [47:0] addr;
  logic [23:0] wdata;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic        tick;
  logic        busy;
  logic [2:0]  grant_id;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  int errors;
  int checks;

  ram_slot_arbiter #(.CHANNELS(3), .ADDR_W(16), .DATA_W(8), .DIV(4)) dut (
    .clk(clk), .reset(reset), .turbo(turbo), .mode(mode),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .tick(tick), .busy(busy), .grant_id(grant_id),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  function automatic int onehot(input logic [2:0] v);
    case (v)
      3'b000:  return -1;
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -2;
    endcase
  endfunction

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_reset(input logic m, input logic t);
    @(negedge clk);
    reset = 1'b1; req = '0; we = '0; turbo = 1'b0;
    repeat (2) @(negedge clk);
    mode = m; turbo = t; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; turbo = 1'b1; mode = 1'b0; req = 3'b111;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b need 000", ack); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h need 00", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d need 0", grant_id); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b need 0", tick); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b need 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b need 0", mem_we); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h need 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h need 00", mem_wdata); end
    turbo = 1'b0;
  endtask

  task automatic test_tdm_fill();
    int n;
    int got_ch[3];
    int got_cyc[3];
    logic [7:0] got_rd[3];
    logic [15:0] tick_hist;
    int exp_cyc[3] = '{6, 10, 14};
    logic [7:0] exp_rd[3] = '{8'h11, 8'h22, 8'h33};
    n = 0; tick_hist = '0;
    for (int i = 0; i < 3; i++) begin got_ch[i] = -1; got_cyc[i] = -1; got_rd[i] = 8'h00; end
    addr = {16'h0C00, 16'h0800, 16'h0400}; wdata = '0;
    do_reset(1'b0, 1'b0);
    req = 3'b111;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      tick_hist = {tick_hist[14:0], tick};
      if (ack !== 3'b000) begin
        if (n < 3) begin got_ch[n] = onehot(ack); got_cyc[n] = k; got_rd[n] = rdata; end
        n++;
        req = req & ~ack;
      end
    end
    checks++; if (tick_hist !== 16'h2222) begin errors++; $display("FAIL tdm_tick_pattern: got %h need 2222", tick_hist); end
    checks++; if (n != 3) begin errors++; $display("FAIL tdm_ack_count: got %0d need 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_ch[i] != i) begin errors++; $display("FAIL tdm_ack_ch[%0d]: got %0d need %0d", i, got_ch[i], i); end
      checks++; if (got_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL tdm_ack_cycle[%0d]: got %0d need %0d", i, got_cyc[i], exp_cyc[i]); end
      checks++; if (got_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL tdm_rdata[%0d]: got %h need %h", i, got_rd[i], exp_rd[i]); end
    end
  endtask

  task automatic test_tdm_empty_slot();
    int n, en_cnt, en_first, other;
    int got_cyc[2];
    logic [7:0] got_rd[2];
    n = 0; en_cnt = 0; en_first = -1; other = 0;
    got_cyc[0] = -1; got_cyc[1] = -1; got_rd[0] = 8'h00; got_rd[1] = 8'h00;
    addr = {16'h0C00, 16'h0800, 16'h0400};
    do_reset(1'b0, 1'b0);
    req = 3'b100;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin en_cnt++; if (en_first < 0) en_first = k; end
      if (ack !== 3'b000) begin
        if (ack !== 3'b100) other++;
        if (n < 2) begin got_cyc[n] = k; got_rd[n] = rdata; end
        n++;
      end
    end
    checks++; if (en_cnt != 2) begin errors++; $display("FAIL empty_mem_en_count: got %0d need 2", en_cnt); end
    checks++; if (en_first != 12) begin errors++; $display("FAIL empty_first_mem_en: got cycle %0d need 12", en_first); end
    checks++; if (n != 2 || other != 0) begin errors++; $display("FAIL empty_acks: got %0d acks (%0d not ch2) need 2 ch2", n, other); end
    checks++; if (got_cyc[0] != 14) begin errors++; $display("FAIL empty_ack0_cycle: got %0d need 14", got_cyc[0]); end
    checks++; if (got_cyc[1] != 26) begin errors++; $display("FAIL empty_ack1_cycle: got %0d need 26", got_cyc[1]); end
    checks++; if (got_rd[1] !== 8'h33) begin errors++; $display("FAIL empty_rdata: got %h need 33", got_rd[1]); end
  endtask

  task automatic test_priority();
    int n;
    int got_ch[7];
    int got_cyc[7];
    logic [7:0] got_rd[7];
    int exp_ch[7] = '{0, 0, 0, 1, 2, 1, 0};
    int exp_cyc[7] = '{6, 10, 14, 18, 22, 26, 30};
    logic [7:0] exp_rd[7] = '{8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h22, 8'h11};
    n = 0;
    for (int i = 0; i < 7; i++) begin got_ch[i] = -1; got_cyc[i] = -1; got_rd[i] = 8'h00; end
    addr = {16'h0C00, 16'h0800, 16'h0400};
    do_reset(1'b1, 1'b0);
    req = 3'b111;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      if (ack !== 3'b000) begin
        if (n < 7) begin got_ch[n] = onehot(ack); got_cyc[n] = k; got_rd[n] = rdata; end
        n++;
      end
      if (k == 14) req[0] = 1'b0;
      if (k == 26) req[0] = 1'b1;
    end
    checks++; if (n != 7) begin errors++; $display("FAIL prio_ack_count: got %0d need 7", n); end
    for (int i = 0; i < 7; i++) begin
      checks++; if (got_ch[i] != exp_ch[i]) begin errors++; $display("FAIL prio_ack_ch[%0d]: got %0d need %0d", i, got_ch[i], exp_ch[i]); end
      checks++; if (got_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL prio_ack_cycle[%0d]: got %0d need %0d", i, got_cyc[i], exp_cyc[i]); end
      checks++; if (got_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL prio_rdata[%0d]: got %h need %h", i, got_rd[i], exp_rd[i]); end
    end
  endtask

  task automatic test_write_path();
    int n, we_cnt, we_cyc;
    logic [15:0] we_a;
    logic [7:0] we_d, rd11;
    int got_ch[3];
    int got_cyc[3];
    logic [7:0] got_rd[3];
    int exp_ch[3] = '{0, 1, 1};
    int exp_cyc[3] = '{6, 10, 22};
    logic [7:0] exp_rd[3] = '{8'h11, 8'h11, 8'hA5};
    n = 0; we_cnt = 0; we_cyc = -1; we_a = '0; we_d = '0; rd11 = '0;
    for (int i = 0; i < 3; i++) begin got_ch[i] = -1; got_cyc[i] = -1; got_rd[i] = 8'h00; end
    addr = {16'h0C00, 16'h1234, 16'h0400}; wdata = {8'h00, 8'hA5, 8'h00};
    do_reset(1'b0, 1'b0);
    req = 3'b011; we = 3'b010;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (mem_we === 1'b1) begin we_cnt++; we_cyc = k; we_a = mem_addr; we_d = mem_wdata; end
      if (k == 11) rd11 = rdata;
      if (ack !== 3'b000) begin
        if (n < 3) begin got_ch[n] = onehot(ack); got_cyc[n] = k; got_rd[n] = rdata; end
        n++;
        if (ack[0]) req[0] = 1'b0;
        if (ack[1]) begin
          if (we[1]) we[1] = 1'b0;
          else req[1] = 1'b0;
        end
      end
    end
    checks++; if (we_cnt != 1) begin errors++; $display("FAIL wr_mem_we_cycles: got %0d need 1", we_cnt); end
    checks++; if (we_cyc != 8) begin errors++; $display("FAIL wr_mem_we_cycle: got %0d need 8", we_cyc); end
    checks++; if (we_a !== 16'h1234) begin errors++; $display("FAIL wr_mem_addr: got %h need 1234", we_a); end
    checks++; if (we_d !== 8'hA5) begin errors++; $display("FAIL wr_mem_wdata: got %h need a5", we_d); end
    checks++; if (rd11 !== 8'h11) begin errors++; $display("FAIL wr_rdata_held: got %h need 11", rd11); end
    checks++; if (n != 3) begin errors++; $display("FAIL wr_ack_count: got %0d need 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_ch[i] != exp_ch[i]) begin errors++; $display("FAIL wr_ack_ch[%0d]: got %0d need %0d", i, got_ch[i], exp_ch[i]); end
      checks++; if (got_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL wr_ack_cycle[%0d]: got %0d need %0d", i, got_cyc[i], exp_cyc[i]); end
      checks++; if (got_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL wr_rdata[%0d]: got %h need %h", i, got_rd[i], exp_rd[i]); end
    end
  endtask

  task automatic test_turbo();
    int n, multi;
    logic tick0, tick_all;
    int got_ch[4];
    int got_cyc[4];
    logic [7:0] got_rd[4];
    int exp_ch[4] = '{0, 1, 2, 0};
    int exp_cyc[4] = '{4, 8, 12, 16};
    logic [7:0] exp_rd[4] = '{8'h11, 8'h22, 8'h33, 8'h11};
    n = 0; multi = 0; tick_all = 1'b1;
    for (int i = 0; i < 4; i++) begin got_ch[i] = -1; got_cyc[i] = -1; got_rd[i] = 8'h00; end
    addr = {16'h0C00, 16'h0800, 16'h0400};
    do_reset(1'b0, 1'b1);
    req = 3'b111;
    tick0 = tick;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      tick_all = tick_all & tick;
      if (ack !== 3'b000) begin
        if (onehot(ack) == -2) multi++;
        if (n < 4) begin got_ch[n] = onehot(ack); got_cyc[n] = k; got_rd[n] = rdata; end
        n++;
      end
    end
    checks++; if (tick0 !== 1'b0) begin errors++; $display("FAIL turbo_tick_delay: got %b need 0", tick0); end
    checks++; if (tick_all !== 1'b1) begin errors++; $display("FAIL turbo_tick_every_clk: got %b need 1", tick_all); end
    checks++; if (multi != 0) begin errors++; $display("FAIL turbo_multi_ack: got %0d need 0", multi); end
    checks++; if (n != 4) begin errors++; $display("FAIL turbo_ack_count: got %0d need 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_ch[i] != exp_ch[i]) begin errors++; $display("FAIL turbo_ack_ch[%0d]: got %0d need %0d", i, got_ch[i], exp_ch[i]); end
      checks++; if (got_cyc[i] != exp_cyc[i]) begin errors++; $display("FAIL turbo_ack_cycle[%0d]: got %0d need %0d", i, got_cyc[i], exp_cyc[i]); end
      checks++; if (got_rd[i] !== exp_rd[i]) begin errors++; $display("FAIL turbo_rdata[%0d]: got %h need %h", i, got_rd[i], exp_rd[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int first_ch, first_cyc, seen;
    first_ch = -1; first_cyc = -1; seen = 0;
    addr = {16'h0C00, 16'h0800, 16'h0400};
    do_reset(1'b0, 1'b0);
    req = 3'b111;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (ack !== 3'b000) begin
        if (first_ch == -1) begin first_ch = onehot(ack); first_cyc = k; end
        req = req & ~ack;
      end
    end
    checks++; if (first_ch != 0 || first_cyc != 6) begin errors++; $display("FAIL mid_pre_ack: got ch %0d cycle %0d need ch 0 cycle 6", first_ch, first_cyc); end
    checks++; if (busy !== 1'b1 || grant_id !== 3'd1) begin errors++; $display("FAIL mid_in_flight: got busy %b grant %0d need busy 1 grant 1", busy, grant_id); end
    checks++; if (rdata !== 8'h11) begin errors++; $display("FAIL mid_pre_rdata: got %h need 11", rdata); end
    reset = 1'b1;
    #1;
    checks++; if (ack !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_ack_busy: got ack %b busy %b need 000 0", ack, busy); end
    checks++; if (grant_id !== 3'd0 || rdata !== 8'h00) begin errors++; $display("FAIL mid_async_grant_rdata: got grant %0d rdata %h need 0 00", grant_id, rdata); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL mid_async_mem_tick: got en %b we %b tick %b need 0 0 0", mem_en, mem_we, tick); end
    req[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ack !== 3'b000) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_ack_in_reset: got %0d acks need 0", seen); end
    reset = 1'b0;
    first_ch = -1; first_cyc = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack !== 3'b000 && first_ch == -1) begin first_ch = onehot(ack); first_cyc = k; end
    end
    checks++; if (first_ch != 0) begin errors++; $display("FAIL mid_post_first_ch: got %0d need 0", first_ch); end
    checks++; if (first_cyc != 6) begin errors++; $display("FAIL mid_post_first_cycle: got %0d need 6", first_cyc); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; reset = 1'b1; turbo = 1'b0; mode = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    errors = 0; checks = 0;
    preload(16'h0400, 8'h11);
    preload(16'h0800, 8'h22);
    preload(16'h0C00, 8'h33);
    preload(16'h1234, 8'h5A);
    test_reset();
    test_tdm_fill();
    test_tdm_empty_slot();
    test_priority();
    test_write_path();
    test_turbo();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
